// File: rtl/regb_fifo_pkg.sv
// Shared definitions for the register-chain FIFO: sizing helpers and the
// per-slot select encodings.
package regb_fifo_pkg;

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        LOAD_IN   = 2'd1,
        LOAD_NEXT = 2'd2,
        CLEAR     = 2'd3
    } slot_sel_e;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Bits needed to hold a fill level in 0..depth inclusive.
    function automatic int count_width(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/regb_fifo_slot.sv
// One storage slot of the FIFO chain: a WIDTH-bit register with a 4-way
// select (hold / load push data / load neighbour / clear) and synchronous reset.
module regb_fifo_slot
    import regb_fifo_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             res_n,
    input  slot_sel_e        sel,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] next_val,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_reg;

    always_ff @(posedge clk) begin
        if (!res_n) begin
            value_reg <= '0;
        end else begin
            unique case (sel)
                LOAD_IN:   value_reg <= load_val;
                LOAD_NEXT: value_reg <= next_val;
                CLEAR:     value_reg <= '0;
                default:   value_reg <= value_reg;
            endcase
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/regb_fifo_flags.sv
// Register-chain FIFO with fixed head (slot 0), fill count and programmable
// almost-full/almost-empty flags. Sticky overflow/underflow under REGB_FIFO_ERR_EN.
module regb_fifo_flags
    import regb_fifo_pkg::*;
#(
    parameter int DEPTH     = 5,
    parameter int WIDTH     = 4,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1
) (
    input  logic                          clk,
    input  logic                          res_n,
    input  logic                          shift_in,
    input  logic [WIDTH-1:0]              in,
    input  logic                          shift_out,
    output logic [WIDTH-1:0]              out,
    output logic                          empty_n,
    output logic                          full,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_TH_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_TH_C = CW'(AEMPTY_TH);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          empty_n_reg;
    logic          full_reg;
    logic          almost_full_reg;
    logic          almost_empty_reg;
    logic          push;
    logic          pop;

    logic [DEPTH-1:0][WIDTH-1:0] slot_q;

    // A full FIFO still accepts a push when the same edge pops a word.
    assign push = shift_in & (~full_reg | shift_out);
    assign pop  = shift_out & empty_n_reg;

    always_comb begin
        count_next = count_reg;
        unique case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            slot_sel_e        sel;
            logic [WIDTH-1:0] next_val;

            if (gi == DEPTH - 1) begin : g_tail
                assign next_val = '0;
            end else begin : g_body
                assign next_val = slot_q[gi+1];
            end

            always_comb begin
                sel = HOLD;
                if (push && pop) begin
                    if (count_reg - CW'(1) == CW'(gi))
                        sel = LOAD_IN;
                    else if (gi == DEPTH - 1)
                        sel = CLEAR;
                    else
                        sel = LOAD_NEXT;
                end else if (pop) begin
                    sel = (gi == DEPTH - 1) ? CLEAR : LOAD_NEXT;
                end else if (push) begin
                    if (count_reg == CW'(gi))
                        sel = LOAD_IN;
                end
            end

            regb_fifo_slot #(
                .WIDTH(WIDTH)
            ) u_slot (
                .clk     (clk),
                .res_n   (res_n),
                .sel     (sel),
                .load_val(in),
                .next_val(next_val),
                .value   (slot_q[gi])
            );
        end
    endgenerate

    // Flags are computed from the next count so they line up with count.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            count_reg        <= '0;
            empty_n_reg      <= 1'b0;
            full_reg         <= 1'b0;
            almost_full_reg  <= 1'b0;
            almost_empty_reg <= 1'b1;
        end else begin
            count_reg        <= count_next;
            empty_n_reg      <= (count_next != '0);
            full_reg         <= (count_next == DEPTH_C);
            almost_full_reg  <= (count_next >= AFULL_TH_C);
            almost_empty_reg <= (count_next <= AEMPTY_TH_C);
        end
    end

`ifdef REGB_FIFO_ERR_EN
    logic overflow_reg;
    logic underflow_reg;

    always_ff @(posedge clk) begin
        if (!res_n) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (shift_in && full_reg && !shift_out)
                overflow_reg <= 1'b1;
            if (shift_out && !empty_n_reg)
                underflow_reg <= 1'b1;
        end
    end

    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign out          = slot_q[0];
    assign empty_n      = empty_n_reg;
    assign full         = full_reg;
    assign almost_full  = almost_full_reg;
    assign almost_empty = almost_empty_reg;
    assign count        = count_reg;

endmodule

// File: doc/regb_fifo_flags.md
Name: regb_fifo_flags

Overview:
Parametrised successor to the team's register-based shift FIFO. Adds a multi-bit data word, a configurable depth, a fill-level count, and programmable almost-full/almost-empty flags. Storage is a linear register chain with a fixed head: slot 0 always drives the output, and a shift-out moves every entry down one slot. Used as a small elastic buffer between streaming stages where depth is at most 16.

Parameters:
- DEPTH, 5: number of storage slots; legal range 2..16.
- WIDTH, 4: data word width in bits; must be at least 1.
- AFULL_TH, DEPTH-1: almost_full asserts when count >= AFULL_TH; legal range 1..DEPTH.
- AEMPTY_TH, 1: almost_empty asserts when count <= AEMPTY_TH; legal range 0..DEPTH-1.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- res_n, input, 1: reset, synchronous and active-low.
- shift_in, input, 1: push request.
- in, input, WIDTH: push data.
- shift_out, input, 1: pop request.
- out, output, WIDTH: head entry (slot 0); registered.
- empty_n, output, 1: 1 when count > 0.
- full, output, 1: 1 when count == DEPTH.
- almost_full, output, 1: count >= AFULL_TH.
- almost_empty, output, 1: count <= AEMPTY_TH.
- count, output, CW: current fill level, where CW = clog2(DEPTH+1).
- overflow, output, 1: sticky error flag (see Optional Feature).
- underflow, output, 1: sticky error flag (see Optional Feature).

Behaviour:
- Reset, when res_n=0 at a clock edge:
  - all slots cleared to 0, count=0.
  - out=0, empty_n=0, full=0, almost_full=0, almost_empty=1, overflow=0, underflow=0.
  - Reset takes priority over any concurrent shift.
- Effective push: push = shift_in & (~full | shift_out).
- Effective pop: pop = shift_out & empty_n.
- Slot update per edge:
  - pop only: slot[k] <= slot[k+1] for k < DEPTH-1; slot[DEPTH-1] <= 0; count-1.
  - push only: slot[count] <= in; count+1.
  - push and pop: slots shift down; slot[count-1] <= in; count unchanged.
  - neither: hold.
- Latency:
  - a word pushed into an empty FIFO appears on out at the next edge; there is no combinational fall-through.
  - out is stable until the next pop.
- Full and pop simultaneous: push is accepted; count stays DEPTH; full stays 1.
- Empty and push simultaneous: pop is ignored (empty_n=0); the word is accepted; count becomes 1.
- Vacated slots are zeroed; when empty_n=0, out=0.
- All flags are registered and derived from next-count, so they are valid in the same cycle as count. There is no combinational path from inputs to outputs.
- count never exceeds DEPTH and never wraps below 0.

Optional Feature:
- Macro: REGB_FIFO_ERR_EN.
- When defined:
  - overflow sets when shift_in=1 and full=1 and shift_out=0.
  - underflow sets when shift_out=1 and empty_n=0.
  - Both flags are sticky until reset.
  - The offending request is still dropped; FIFO state is unchanged by it.
- When undefined: overflow and underflow are tied to 0; no error logic is synthesised. Ports exist in both builds.

Decomposition:
- Shared package regb_fifo_pkg holds:
  - a clog2 constant function.
  - a count-width localparam helper.
  - slot-mux select encodings: HOLD, LOAD_IN, LOAD_NEXT, CLEAR.
- One sub-module, regb_fifo_slot: a WIDTH-bit register with a 4-way select mux and synchronous reset, instantiated DEPTH times in a generate loop.
- Top level holds the count register, the per-slot select decode and the flag registers.

Test Plan (DEPTH=4, WIDTH=8, AFULL_TH=3, AEMPTY_TH=1):
- Reset then idle -> out=0x00, count=0, empty_n=0, almost_empty=1, full=0.
- Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles:
  - count steps 1,2,3,4.
  - almost_empty drops at count=2; almost_full rises at count=3; full=1 at count=4.
  - out=0x11 from the cycle after the first push.
- Full, then shift_in=1 with in=0x55 and shift_out=1 in one cycle -> count stays 4; out becomes 0x22; subsequent pops give 0x33, 0x44, 0x55.
- Empty, then shift_in=1 with in=0xAA and shift_out=1 -> count=1, out=0xAA next cycle, underflow stays 0.
- With REGB_FIFO_ERR_EN:
  - push 0x66 while full with no pop -> overflow=1 (sticky), count=4, contents unchanged.
  - pop while empty -> underflow=1.
  - res_n=0 for one edge -> both flags clear.
- Assert res_n=0 mid-stream at count=2 with shift_in=1 -> next cycle count=0, out=0x00, empty_n=0; the pushed word is discarded.
